iir_mac_sequencer: RTL and testbench

- Time-multiplexed direct-form-I IIR filter controller: one shared signed multiplier-accumulator is sequenced across all zero and pole taps for each input sample.
- Replaces the fully parallel zero/pole coefficient banks in the modulator/demodulator filter chain where multiplier count matters more than throughput.
- Holds loadable coefficient and history registers, runs the tap schedule via an FSM, scales by a0 with a shift, saturates, and presents a valid-qualified output.

---
 rtl/iir_mac_sequencer.sv | 152 +++++++++++++++
 tb/tb_iir_mac_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_sequencer.sv
// Direct-form-I IIR filter built around one shared signed MAC, stepped through
// the zero taps then the pole taps for each sample, then scaled by a0 and saturated.
module iir_mac_sequencer #(
   parameter int ORDER    = 6,
   parameter int DW       = 15,
   parameter int CW       = 12,
   parameter int AW       = 32,
   parameter int A0_SHIFT = 9
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clr,
   input  logic signed [DW-1:0] i_din,
   input  logic                 i_din_valid,
   output logic                 o_din_ready,
   output logic signed [DW-1:0] o_dout,
   output logic                 o_dout_valid,
   input  logic                 i_cfg_we,
   input  logic [3:0]           i_cfg_addr,
   input  logic signed [CW-1:0] i_cfg_data,
   output logic                 o_busy,
   output logic                 o_sat_flag,
   output logic                 o_cfg_err
);
   localparam int NC = 2*ORDER+1;
   localparam int IW = $clog2(ORDER+1);
   localparam int PW = DW+CW;
   localparam logic signed [AW-1:0] YMAX = AW'(2**(DW-1)-1);
   localparam logic signed [AW-1:0] YMIN = ~YMAX;

   typedef enum logic [1:0] {S_IDLE, S_ZERO, S_POLE, S_SCALE} state_t;

   state_t               r_state, w_next;
   logic [IW-1:0]        r_idx;
   logic signed [CW-1:0] r_coef [NC];
   logic signed [DW-1:0] r_x [ORDER+1];
   logic signed [DW-1:0] r_y [ORDER];
   logic signed [AW-1:0] r_acc;

   logic                 w_accept, w_last, w_sat;
   logic signed [CW-1:0] w_coef;
   logic signed [DW-1:0] w_samp, w_y;
   logic signed [PW-1:0] w_prod;
   logic signed [AW-1:0] w_prod_ext, w_shift;

   assign w_accept = i_din_valid & o_din_ready & ~i_clr;
   assign w_last   = (r_idx == IW'(ORDER));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (i_clr) w_next = S_IDLE;
      else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ZERO;
            S_ZERO:  if (w_last)   w_next = S_POLE;
            S_POLE:  if (w_last)   w_next = S_SCALE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      o_busy      = (r_state != S_IDLE);
      o_din_ready = (r_state == S_IDLE);
   end

   // Operand select for the single multiplier: b[idx]*x[idx] or a[idx]*y[idx-1]
   always_comb begin
      w_coef = '0;
      w_samp = '0;
      if (r_state == S_POLE) begin
         for (int k = 1; k <= ORDER; k++)
            if (r_idx == IW'(k)) begin
               w_coef = r_coef[ORDER+k];
               w_samp = r_y[k-1];
            end
      end else begin
         for (int k = 0; k <= ORDER; k++)
            if (r_idx == IW'(k)) begin
               w_coef = r_coef[k];
               w_samp = r_x[k];
            end
      end
   end

   assign w_prod     = w_coef * w_samp;
   assign w_prod_ext = AW'(w_prod);
   assign w_shift    = r_acc >>> A0_SHIFT;
   assign w_sat      = (w_shift > YMAX) || (w_shift < YMIN);
   assign w_y        = (w_shift > YMAX) ? YMAX[DW-1:0] :
                       (w_shift < YMIN) ? YMIN[DW-1:0] : w_shift[DW-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NC; k++)    r_coef[k] <= '0;
         for (int k = 0; k <= ORDER; k++) r_x[k]   <= '0;
         for (int k = 0; k < ORDER; k++)  r_y[k]   <= '0;
         r_acc        <= '0;
         r_idx        <= '0;
         o_dout       <= '0;
         o_dout_valid <= 1'b0;
         o_sat_flag   <= 1'b0;
         o_cfg_err    <= 1'b0;
      end else begin
         o_dout_valid <= 1'b0;
         // Coefficients only change in IDLE, so a write beside an accept is seen by that sample
         if (i_cfg_we) begin
            if (r_state != S_IDLE || i_cfg_addr > 4'(2*ORDER)) o_cfg_err <= 1'b1;
            else
               for (int k = 0; k < NC; k++)
                  if (i_cfg_addr == 4'(k)) r_coef[k] <= i_cfg_data;
         end
         if (i_clr) begin
            for (int k = 0; k <= ORDER; k++) r_x[k] <= '0;
            for (int k = 0; k < ORDER; k++)  r_y[k] <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            o_sat_flag <= 1'b0;
            o_cfg_err  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: if (w_accept) begin
                  for (int k = ORDER; k > 0; k--) r_x[k] <= r_x[k-1];
                  r_x[0] <= i_din;
                  r_acc  <= '0;
                  r_idx  <= '0;
               end
               S_ZERO: begin
                  r_acc <= r_acc + w_prod_ext;
                  r_idx <= w_last ? IW'(1) : r_idx + 1'b1;
               end
               S_POLE: begin
                  r_acc <= r_acc - w_prod_ext;
                  r_idx <= r_idx + 1'b1;
               end
               default: begin
                  o_dout       <= w_y;
                  o_dout_valid <= 1'b1;
                  if (w_sat) o_sat_flag <= 1'b1;
                  for (int k = ORDER-1; k > 0; k--) r_y[k] <= r_y[k-1];
                  r_y[0] <= w_y;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Scoreboard bench for iir_mac_sequencer: driver pushes expected dout and accept
// cycle; a negedge monitor pops on every dout_valid and checks value and latency.
module tb_iir_mac_sequencer;
   localparam int DW = 15;
   localparam int CW = 12;

   logic                 clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
   logic signed [DW-1:0] din = '0;
   logic                 din_valid = 1'b0, cfg_we = 1'b0;
   logic [3:0]           cfg_addr = '0;
   logic signed [CW-1:0] cfg_data = '0;
   logic                 din_ready, dout_valid, busy, sat_flag, cfg_err;
   logic signed [DW-1:0] dout;

   iir_mac_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
      .i_din(din), .i_din_valid(din_valid), .o_din_ready(din_ready),
      .o_dout(dout), .o_dout_valid(dout_valid),
      .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
      .o_busy(busy), .o_sat_flag(sat_flag), .o_cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   int exp_q[$];
   int acc_q[$];
   int last_acc = 0;
   int m_e, m_a;

   task automatic chk(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (dout_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_dout: got %0d expected no output", int'(dout));
         end else begin
            m_e = exp_q.pop_front();
            m_a = acc_q.pop_front();
            chk("dout", int'(dout), m_e);
            chk("latency", cyc - m_a, 14);
         end
      end
   end

   task automatic cfg(input int addr, input int data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = CW'(data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge, valid left high
   task automatic send(input int v, input bit expect_out, input int want);
      int n = 0;
      din = DW'(v);
      din_valid = 1'b1;
      while (!din_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got no din_ready expected ready within 100 cycles");
      end
      @(negedge clk);
      last_acc = cyc;
      if (expect_out) begin
         exp_q.push_back(want);
         acc_q.push_back(last_acc);
      end
   endtask

   task automatic one(input int v, input int want);
      send(v, 1'b1, want);
      din_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   int hs_vals[5] = '{11, -22, 333, -4444, 5555};
   int prev;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_dout", int'(dout), 0);
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_ready", int'(din_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sat", int'(sat_flag), 0);
      chk("rst_err", int'(cfg_err), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // pass-through
      cfg(0, 512);
      one(100, 100);
      one(-200, -200);
      one(16383, 16383);
      drain();
      chk("pass_sat", int'(sat_flag), 0);

      // pole recursion
      pulse_clr();
      cfg(7, -256);
      one(1000, 1000);
      one(0, 500); one(0, 250); one(0, 125); one(0, 62); one(0, 31);
      drain();

      // saturation, both rails
      pulse_clr();
      cfg(7, 0);
      cfg(1, 512);
      one(16000, 16000);
      one(16000, 16383);
      drain();
      chk("sat_pos", int'(sat_flag), 1);
      pulse_clr();
      chk("sat_clr", int'(sat_flag), 0);
      one(-16000, -16000);
      one(-16000, -16384);
      drain();
      chk("sat_neg", int'(sat_flag), 1);
      pulse_clr();
      chk("sat_clr2", int'(sat_flag), 0);

      // continuous din_valid
      cfg(1, 0);
      pulse_clr();
      for (int i = 0; i < 5; i++) begin
         send(hs_vals[i], 1'b1, hs_vals[i]);
         if (i > 0) chk("spacing", last_acc - prev, 15);
         prev = last_acc;
      end
      din_valid = 1'b0;
      drain();

      // config guard: write while busy, then out-of-range address
      send(300, 1'b1, 300);
      din_valid = 1'b0;
      chk("busy_zero", int'(busy), 1);
      cfg(0, 100);
      drain();
      chk("err_busy", int'(cfg_err), 1);
      pulse_clr();
      chk("err_clr", int'(cfg_err), 0);
      cfg(13, 77);
      chk("err_addr", int'(cfg_err), 1);
      one(7, 7);
      drain();
      pulse_clr();

      // write and accept on the same edge: new b0 applies
      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 12'sd1024;
      din = 15'sd50; din_valid = 1'b1;
      @(negedge clk);
      last_acc = cyc;
      exp_q.push_back(100);
      acc_q.push_back(last_acc);
      cfg_we = 1'b0; din_valid = 1'b0;
      drain();
      chk("err_same_edge", int'(cfg_err), 0);
      cfg(0, 512);

      // reset during POLE
      send(1234, 1'b0, 0);
      din_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("pole_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_dout", int'(dout), 0);
      chk("arst_valid", int'(dout_valid), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_ready", int'(din_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // clr after impulse removes tail
      cfg(0, 512);
      cfg(7, -256);
      one(1000, 1000);
      drain();
      pulse_clr();
      one(0, 0);
      drain();

      // clr mid-computation: no output, back to idle
      send(555, 1'b0, 0);
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      pulse_clr();
      repeat (20) @(negedge clk);
      chk("clr_idle", int'(busy), 0);
      chk("clr_dout_kept", int'(dout), 0);
      one(20, 20);
      drain();

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
